// File: rtl/chip16_vector_checker_pkg.sv
// Shared definitions for the 16-bit chip vector checker: op modes, FSM states,
// LFSR tap, directed vectors and the failure-capture record.
package chip16_vector_checker_pkg;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned ERR_W        = 8;
    localparam int unsigned NUM_DIRECTED = 4;

    localparam logic [1:0] MODE_OR   = 2'b00;
    localparam logic [1:0] MODE_AND  = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_NAND = 2'b11;

    localparam logic [DATA_W-1:0] LFSR_TAP = 16'hB400;

    // Bit k set means directed vector k drives all-ones on that operand.
    localparam logic [NUM_DIRECTED-1:0] DIR_A_ONES = 4'b1100;
    localparam logic [NUM_DIRECTED-1:0] DIR_B_ONES = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] out;
    } fail_rec_t;

    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAP) : (s >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] expected_out(input logic [1:0]        m,
                                                       input logic [DATA_W-1:0] x,
                                                       input logic [DATA_W-1:0] y);
        logic [DATA_W-1:0] r;
        case (m)
            MODE_OR:  r = x | y;
            MODE_AND: r = x & y;
            MODE_XOR: r = x ^ y;
            default:  r = ~(x & y);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/chip16_vector_checker_lfsr16.sv
// 16-bit Galois LFSR (right shift) with seed reload and single-step advance.
module lfsr16
    import chip16_vector_checker_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              advance,
    output logic [DATA_W-1:0] state
);

    logic [DATA_W-1:0] state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= seed;
        end else if (load) begin
            state_q <= seed;
        end else if (advance) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/chip16_vector_checker.sv
// Stimulus/response checker for 16-bit two-operand chips: drives a/b, samples
// dut_out after a settle window, counts mismatches and records the first one.
module chip16_vector_checker
    import chip16_vector_checker_pkg::*;
#(
    parameter int unsigned       NUM_VECTORS   = 32,
    parameter int unsigned       SETTLE_CYCLES = 1,
    parameter logic [DATA_W-1:0] SEED_A        = 16'hACE1,
    parameter logic [DATA_W-1:0] SEED_B        = 16'h1D2B
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] dut_out,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              fail_valid,
    output logic [DATA_W-1:0] fail_a,
    output logic [DATA_W-1:0] fail_b,
    output logic [DATA_W-1:0] fail_out
);

    localparam int unsigned IDX_W = $clog2(NUM_VECTORS);
    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
    localparam logic [IDX_W-1:0] LAST_DIR    = IDX_W'(NUM_DIRECTED - 1);
    localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              fail_valid_q, fail_valid_d;
    fail_rec_t         fail_q, fail_d;

    logic              lfsr_load_c, lfsr_adv_c;
    logic [DATA_W-1:0] lfsr_a_c, lfsr_b_c;
    logic [IDX_W-1:0]  idx_inc_c;
    logic [1:0]        dir_sel_c;

    lfsr16 u_lfsr_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load_c),
        .seed    (SEED_A),
        .advance (lfsr_adv_c),
        .state   (lfsr_a_c)
    );

    lfsr16 u_lfsr_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load_c),
        .seed    (SEED_B),
        .advance (lfsr_adv_c),
        .state   (lfsr_b_c)
    );

    assign idx_inc_c = idx_q + IDX_W'(1);
    assign dir_sel_c = idx_inc_c[1:0];

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        a_d          = a_q;
        b_d          = b_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_d       = fail_q;
        lfsr_load_c  = 1'b0;
        lfsr_adv_c   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_DRIVE;
                    mode_d       = mode;
                    idx_d        = '0;
                    settle_d     = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_d       = '0;
                    lfsr_load_c  = 1'b1;
                    a_d          = {DATA_W{DIR_A_ONES[0]}};
                    b_d          = {DATA_W{DIR_B_ONES[0]}};
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (settle_q == LAST_SETTLE) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_NEXT;
                if (dut_out != expected_out(mode_q, a_q, b_q)) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_d.a     = a_q;
                        fail_d.b     = b_q;
                        fail_d.out   = dut_out;
                    end
                end
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    a_d     = '0;
                    b_d     = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0);
                end else begin
                    state_d  = ST_DRIVE;
                    idx_d    = idx_inc_c;
                    settle_d = '0;
                    // Directed vectors first, then the seeds, then stepped LFSRs.
                    if (idx_q < LAST_DIR) begin
                        a_d = {DATA_W{DIR_A_ONES[dir_sel_c]}};
                        b_d = {DATA_W{DIR_B_ONES[dir_sel_c]}};
                    end else if (idx_q == LAST_DIR) begin
                        a_d = lfsr_a_c;
                        b_d = lfsr_b_c;
                    end else begin
                        lfsr_adv_c = 1'b1;
                        a_d        = lfsr_next(lfsr_a_c);
                        b_d        = lfsr_next(lfsr_b_c);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= '0;
            idx_q        <= '0;
            settle_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_q       <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_q       <= fail_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_q.a;
    assign fail_b     = fail_q.b;
    assign fail_out   = fail_q.out;

endmodule

// File: tb/tb_chip16_vector_checker.sv
// Bench for chip16_vector_checker: three checker instances, each wired to a
// configurable chip model with stuck-at faults, against a vector-list model.
module tb_chip16_vector_checker;

    logic clk;
    logic rst_n;

    logic        start_r [3];
    logic [1:0]  mode_r  [3];
    logic [15:0] dout    [3];
    logic [15:0] a_w     [3];
    logic [15:0] b_w     [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        pass_w  [3];
    logic [7:0]  err_w   [3];
    logic        fv_w    [3];
    logic [15:0] fa_w    [3];
    logic [15:0] fb_w    [3];
    logic [15:0] fo_w    [3];

    // Chip-under-test configuration per instance.
    logic [1:0]  kind    [3];
    logic [15:0] s0      [3];
    logic [15:0] s1      [3];
    logic        tie_en  [3];
    logic [15:0] tie_v   [3];
    logic        garble  [3];

    int n_tests;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    chip16_vector_checker #(.NUM_VECTORS(4), .SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .mode(mode_r[0]), .dut_out(dout[0]),
        .a(a_w[0]), .b(b_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_valid(fv_w[0]), .fail_a(fa_w[0]), .fail_b(fb_w[0]),
        .fail_out(fo_w[0]));

    chip16_vector_checker #(.NUM_VECTORS(6), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .mode(mode_r[1]), .dut_out(dout[1]),
        .a(a_w[1]), .b(b_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_valid(fv_w[1]), .fail_a(fa_w[1]), .fail_b(fb_w[1]),
        .fail_out(fo_w[1]));

    chip16_vector_checker #(.NUM_VECTORS(300), .SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]), .mode(mode_r[2]), .dut_out(dout[2]),
        .a(a_w[2]), .b(b_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .fail_valid(fv_w[2]), .fail_a(fa_w[2]), .fail_b(fb_w[2]),
        .fail_out(fo_w[2]));

    function automatic int nv(input int i);
        return (i == 0) ? 4 : (i == 1) ? 6 : 300;
    endfunction

    function automatic int st(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic logic [15:0] op16(input logic [1:0] m, input logic [15:0] x,
                                         input logic [15:0] y);
        case (m)
            2'd0:    return x | y;
            2'd1:    return x & y;
            2'd2:    return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    function automatic logic [15:0] chip_resp(input int i, input logic [15:0] x,
                                              input logic [15:0] y);
        if (tie_en[i]) return tie_v[i];
        return (op16(kind[i], x, y) & ~s0[i]) | s1[i];
    endfunction

    // Chip models; outputs are inverted whenever the checker must not be sampling.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dout[i] = chip_resp(i, a_w[i], b_w[i]);
            if (garble[i]) dout[i] = ~dout[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One run on instance i; extra_start pulses start mid-run, rst_cyc>0 resets mid-run.
    task automatic run(input int i, input logic [1:0] m, input string name,
                       input int extra_start, input int rst_cyc);
        logic [15:0] va[$];
        logic [15:0] vb[$];
        logic [15:0] la, lb, x, y, r;
        int          errs, errs_at, n, p, k, ph;
        logic        fv;
        logic [15:0] fa, fb, fo;
        bit          chk_cyc;

        n = nv(i);
        p = st(i) + 2;
        la = 16'hACE1;
        lb = 16'h1D2B;
        errs = 0;
        fv = 1'b0;
        fa = '0; fb = '0; fo = '0;
        for (int v = 0; v < n; v++) begin
            if (v == 0)      begin x = 16'h0000; y = 16'h0000; end
            else if (v == 1) begin x = 16'h0000; y = 16'hFFFF; end
            else if (v == 2) begin x = 16'hFFFF; y = 16'h0000; end
            else if (v == 3) begin x = 16'hFFFF; y = 16'hFFFF; end
            else begin
                if (v > 4) begin
                    la = (la >> 1) ^ (la[0] ? 16'hB400 : 16'h0000);
                    lb = (lb >> 1) ^ (lb[0] ? 16'hB400 : 16'h0000);
                end
                x = la;
                y = lb;
            end
            va.push_back(x);
            vb.push_back(y);
            r = chip_resp(i, x, y);
            if (r != op16(m, x, y)) begin
                if (errs < 255) errs++;
                if (!fv) begin fv = 1'b1; fa = x; fb = y; fo = r; end
            end
        end

        @(negedge clk);
        mode_r[i]  = m;
        start_r[i] = 1'b1;
        garble[i]  = 1'b1;
        for (int cyc = 1; cyc <= n * p + 1; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            start_r[i] = (cyc == extra_start);
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                chk({name, "/rst_ctl"}, 64'({busy_w[i], done_w[i], pass_w[i], fv_w[i]}), 64'd0);
                chk({name, "/rst_ab"}, 64'({a_w[i], b_w[i]}), 64'd0);
                chk({name, "/rst_err"}, 64'(err_w[i]), 64'd0);
                rst_n = 1'b1;
                break;
            end
            k  = (cyc - 1) / p;
            ph = (cyc - 1) % p;
            chk_cyc = (ph == st(i)) && (cyc <= n * p);
            garble[i] = !chk_cyc;
            if (chk_cyc)
                chk($sformatf("%s/v%0d", name, k), 64'({busy_w[i], a_w[i], b_w[i]}),
                    64'({1'b1, va[k], vb[k]}));
            if (rst_cyc > 0 && cyc == rst_cyc) begin
                errs_at = 0;
                for (int v = 0; v < k; v++)
                    if (chip_resp(i, va[v], vb[v]) != op16(m, va[v], vb[v])) errs_at++;
                chk({name, "/pre_rst_err"}, 64'(err_w[i]), 64'(errs_at));
                rst_n = 1'b0;
            end
            if (cyc == n * p)
                chk({name, "/last_next"}, 64'({busy_w[i], done_w[i]}), 64'b10);
            if (cyc == n * p + 1) begin
                chk({name, "/done"}, 64'({busy_w[i], done_w[i], pass_w[i]}),
                    64'({1'b0, 1'b1, errs == 0}));
                chk({name, "/err"}, 64'(err_w[i]), 64'(errs));
                chk({name, "/fail"}, 64'({fv_w[i], fa_w[i], fb_w[i], fo_w[i]}),
                    64'({fv, fa, fb, fo}));
                chk({name, "/ab_zero"}, 64'({a_w[i], b_w[i]}), 64'd0);
            end
        end
        garble[i] = 1'b0;
    endtask

    task automatic set_chip(input int i, input logic [1:0] kd, input logic [15:0] m0,
                            input logic [15:0] m1, input logic te, input logic [15:0] tv);
        kind[i] = kd; s0[i] = m0; s1[i] = m1; tie_en[i] = te; tie_v[i] = tv;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0;
            mode_r[i]  = 2'd0;
            garble[i]  = 1'b0;
            set_chip(i, 2'd0, 16'h0, 16'h0, 1'b0, 16'h0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_ctl%0d", i),
                64'({busy_w[i], done_w[i], pass_w[i], fv_w[i], err_w[i]}), 64'd0);
            chk($sformatf("reset_data%0d", i),
                64'({a_w[i], b_w[i], fa_w[i] | fb_w[i] | fo_w[i]}), 64'd0);
        end
        rst_n = 1'b1;

        run(0, 2'd0, "or_clean", 0, 0);
        set_chip(0, 2'd0, 16'h0001, 16'h0, 1'b0, 16'h0);
        run(0, 2'd0, "or_bit0_stuck", 0, 0);
        set_chip(0, 2'd0, 16'h0, 16'h0, 1'b0, 16'h0);
        run(0, 2'd1, "and_vs_or", 0, 0);
        run(1, 2'd0, "or_six", 0, 0);
        run(0, 2'd0, "start_busy", 4, 0);
        set_chip(0, 2'd0, 16'h8000, 16'h0, 1'b0, 16'h0);
        run(0, 2'd0, "mid_reset", 0, 7);
        set_chip(2, 2'd0, 16'h0, 16'h0, 1'b1, 16'h5A5A);
        run(2, 2'd0, "saturate", 0, 0);

        // Randomized chips, faults and modes.
        for (int t = 0; t < 24; t++) begin
            int          i;
            logic [15:0] m0, m1;
            i  = (t % 8 == 7) ? 2 : int'($urandom_range(0, 1));
            m0 = ($urandom_range(0, 1) == 1) ? (16'($urandom) & 16'($urandom) & 16'($urandom)) : 16'h0;
            m1 = ($urandom_range(0, 2) == 2) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            set_chip(i, 2'($urandom_range(0, 3)), m0, m1, 1'b0, 16'h0);
            run(i, 2'($urandom_range(0, 3)), $sformatf("rand%0d", t), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
